// File: rtl/core_mem_arbiter_pkg.sv
// Shared widths, owner encoding and FSM state encodings for the core memory arbiter.
package core_mem_arbiter_pkg;

    localparam int MEM_ADDR_WIDTH     = 10;
    localparam int REG_DATA_WIDTH     = 32;
    localparam int MEM_TRANSFER_WIDTH = REG_DATA_WIDTH / 8;

    localparam logic OWNER_PROG = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam logic [1:0] ARB       = 2'd0;
    localparam logic [1:0] HOLD_PROG = 2'd1;
    localparam logic [1:0] HOLD_DATA = 2'd2;

endpackage

// File: rtl/core_mem_owner_fifo.sv
// 1-bit owner FIFO: remembers which port issued each outstanding memory transaction.
module core_mem_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_owner,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]    count;
    logic [CW-1:0]    wr_idx;
    logic [DEPTH-1:0] slots;
    logic [DEPTH-1:0] slots_nxt;

    // Head lives in slot 0; a pop shifts everything down, so a same-cycle push lands one slot lower.
    always_comb begin
        wr_idx    = pop ? count - 1'b1 : count;
        slots_nxt = pop ? (slots >> 1) : slots;
        for (int i = 0; i < DEPTH; i++) begin
            if (push && wr_idx == CW'(i))
                slots_nxt[i] = push_owner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            slots <= '0;
        end else begin
            slots <= slots_nxt;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = slots[0];

endmodule

// File: rtl/core_mem_arbiter.sv
// Merges the core's fetch and data ports onto one single-port memory and routes
// responses back to the issuing port in order.
module core_mem_arbiter #(
    parameter int MEM_ADDR_WIDTH  = core_mem_arbiter_pkg::MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH      = core_mem_arbiter_pkg::REG_DATA_WIDTH,
    parameter int TRANSFER_WIDTH  = core_mem_arbiter_pkg::MEM_TRANSFER_WIDTH,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      prog_req_i,
    input  logic [MEM_ADDR_WIDTH-1:0] prog_addr_i,
    output logic                      prog_gnt_o,
    output logic                      prog_rvalid_o,
    output logic [DATA_WIDTH-1:0]     prog_rdata_o,
    input  logic                      data_req_i,
    input  logic                      data_we_i,
    input  logic [TRANSFER_WIDTH-1:0] data_be_i,
    input  logic [MEM_ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0]     data_wdata_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    output logic [DATA_WIDTH-1:0]     data_rdata_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [TRANSFER_WIDTH-1:0] mem_be_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    output logic                      err_o
);

    import core_mem_arbiter_pkg::*;

    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    logic [1:0]    state, state_nxt;
    logic [SW-1:0] starve_cnt;
    logic          starved;
    logic          sel_data, sel_req, hs, pop;
    logic          fifo_full, fifo_empty, fifo_head;

    assign starved = (starve_cnt == SW'(STARVE_LIMIT));

    // While holding, the selection is frozen so the presented request cannot change under the memory.
    always_comb begin
        case (state)
            HOLD_PROG: sel_data = 1'b0;
            HOLD_DATA: sel_data = 1'b1;
            default:   sel_data = data_req_i && !(prog_req_i && starved);
        endcase
    end

    assign sel_req     = sel_data ? data_req_i : prog_req_i;
    assign mem_req_o   = rst_n && sel_req && !fifo_full;
    assign mem_we_o    = sel_data && data_we_i;
    assign mem_be_o    = sel_data ? data_be_i : '1;
    assign mem_addr_o  = sel_data ? data_addr_i : prog_addr_i;
    assign mem_wdata_o = data_wdata_i;

    assign hs         = mem_req_o && mem_gnt_i;
    assign prog_gnt_o = hs && !sel_data;
    assign data_gnt_o = hs && sel_data;

    always_comb begin
        state_nxt = state;
        if (!fifo_full) begin
            if (state == ARB) begin
                if (sel_req && !mem_gnt_i)
                    state_nxt = sel_data ? HOLD_DATA : HOLD_PROG;
            end else if (!sel_req || mem_gnt_i) begin
                state_nxt = ARB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB;
            starve_cnt <= '0;
            err_o      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!prog_req_i || prog_gnt_o)
                starve_cnt <= '0;
            else if (data_gnt_o && !starved)
                starve_cnt <= starve_cnt + 1'b1;
            if (mem_rvalid_i && fifo_empty)
                err_o <= 1'b1;
        end
    end

    assign pop           = mem_rvalid_i && !fifo_empty;
    assign prog_rvalid_o = pop && (fifo_head == OWNER_PROG);
    assign data_rvalid_o = pop && (fifo_head == OWNER_DATA);
    assign prog_rdata_o  = mem_rdata_i;
    assign data_rdata_o  = mem_rdata_i;

    core_mem_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (hs),
        .push_owner (sel_data ? OWNER_DATA : OWNER_PROG),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head)
    );

endmodule
